// File: rtl/divider_pkg.sv
// Shared definitions for the iterative divider: FSM encoding, the
// divide-by-zero quotient fill bit and a constant-evaluable log2 helper.
package divider_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // Divide by zero returns a quotient with every bit set.
  localparam logic DBZ_QUOT_BIT = 1'b1;

  // Ceiling log2, used to size the iteration counter (0 .. WIDTH-1).
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned v;
    int unsigned r;
    v = value - 32'd1;
    r = 32'd0;
    for (int i = 0; i < 32; i++) begin
      if (v != 32'd0) begin
        r = r + 32'd1;
        v = v >> 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/div_restore_step.sv
// One radix-2 restoring division iteration: shift in the next dividend bit,
// trial-subtract the divisor magnitude, keep the difference if non-negative.
module div_restore_step
  import divider_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor_mag,
  output logic [WIDTH:0]   rem_out,
  output logic             quot_bit
);

  logic [WIDTH+1:0] shifted_s;
  logic [WIDTH+1:0] diff_s;

  assign shifted_s = {rem_in, dividend_bit};
  assign diff_s    = shifted_s - {2'b00, divisor_mag};

  // Keep the trial difference when it did not underflow, otherwise restore.
  always_comb begin
    rem_out  = shifted_s[WIDTH:0];
    quot_bit = 1'b0;
    if (diff_s[WIDTH+1] == 1'b0) begin
      rem_out  = diff_s[WIDTH:0];
      quot_bit = 1'b1;
    end else begin
      rem_out  = shifted_s[WIDTH:0];
      quot_bit = 1'b0;
    end
  end

endmodule

// File: rtl/iter_divider.sv
// Multi-cycle signed/unsigned integer divider for the EX stage.
// Restoring radix-2 core on operand magnitudes, fixed WIDTH-cycle latency,
// valid/ready on both sides, tag passthrough and synchronous flush.
module iter_divider
  import divider_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [WIDTH-1:0] in_dividend,
  input  logic [WIDTH-1:0] in_divisor,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_quot,
  output logic [WIDTH-1:0] out_rem,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_dbz
);

  localparam int CNT_W = (clog2(WIDTH) < 1) ? 1 : int'(clog2(WIDTH));
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO_W   = WIDTH'(0);
  localparam logic [WIDTH:0]   ZERO_R   = (WIDTH + 1)'(0);
  localparam logic [TAG_W-1:0] ZERO_T   = TAG_W'(0);
  localparam logic [WIDTH-1:0] DBZ_QUOT = {WIDTH{DBZ_QUOT_BIT}};

  // Two's-complement negation at operand width.
  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return (~v) + ONE_W;
  endfunction

  div_state_e       state_r;
  div_state_e       state_nxt_s;
  logic             accept_s;
  logic             last_iter_s;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH:0]   rem_r;
  logic [WIDTH-1:0] quot_r;
  logic [WIDTH-1:0] div_mag_r;
  logic [WIDTH-1:0] dividend_r;
  logic             neg_q_r;
  logic             neg_r_r;
  logic             dbz_r;
  logic [TAG_W-1:0] tag_r;
  logic [WIDTH-1:0] dividend_mag_s;
  logic [WIDTH-1:0] divisor_mag_s;
  logic [WIDTH:0]   step_rem_s;
  logic             step_qbit_s;
  logic [WIDTH-1:0] q_mag_s;
  logic [WIDTH-1:0] quot_res_s;
  logic [WIDTH-1:0] rem_res_s;
  logic             out_valid_r;
  logic [WIDTH-1:0] out_quot_r;
  logic [WIDTH-1:0] out_rem_r;
  logic [TAG_W-1:0] out_tag_r;
  logic             out_dbz_r;

  assign in_ready    = (state_r == DIV_IDLE) | ((state_r == DIV_DONE) & out_ready);
  assign accept_s    = in_valid & in_ready & ~flush;
  assign last_iter_s = (state_r == DIV_BUSY) && (cnt_r == CNT_LAST);

  assign out_valid = out_valid_r;
  assign out_quot  = out_quot_r;
  assign out_rem   = out_rem_r;
  assign out_tag   = out_tag_r;
  assign out_dbz   = out_dbz_r;

  div_restore_step #(.WIDTH(WIDTH)) u_step (
    .rem_in       (rem_r),
    .dividend_bit (quot_r[WIDTH-1]),
    .divisor_mag  (div_mag_r),
    .rem_out      (step_rem_s),
    .quot_bit     (step_qbit_s)
  );

  // Operand magnitudes; raw operands are used in unsigned mode.
  always_comb begin
    dividend_mag_s = in_dividend;
    divisor_mag_s  = in_divisor;
    if (in_signed && in_dividend[WIDTH-1]) begin
      dividend_mag_s = neg_w(in_dividend);
    end else begin
      dividend_mag_s = in_dividend;
    end
    if (in_signed && in_divisor[WIDTH-1]) begin
      divisor_mag_s = neg_w(in_divisor);
    end else begin
      divisor_mag_s = in_divisor;
    end
  end

  // Final sign correction of the last iteration, with divide-by-zero override.
  always_comb begin
    q_mag_s    = {quot_r[WIDTH-2:0], step_qbit_s};
    quot_res_s = q_mag_s;
    rem_res_s  = step_rem_s[WIDTH-1:0];
    if (dbz_r) begin
      quot_res_s = DBZ_QUOT;
      rem_res_s  = dividend_r;
    end else begin
      quot_res_s = neg_q_r ? neg_w(q_mag_s) : q_mag_s;
      rem_res_s  = neg_r_r ? neg_w(step_rem_s[WIDTH-1:0]) : step_rem_s[WIDTH-1:0];
    end
  end

  // Next-state logic; flush overrides every transition.
  always_comb begin
    state_nxt_s = state_r;
    if (flush) begin
      state_nxt_s = DIV_IDLE;
    end else begin
      case (state_r)
        DIV_IDLE: state_nxt_s = accept_s ? DIV_BUSY : DIV_IDLE;
        DIV_BUSY: state_nxt_s = last_iter_s ? DIV_DONE : DIV_BUSY;
        DIV_DONE: begin
          if (accept_s) begin
            state_nxt_s = DIV_BUSY;
          end else if (out_ready) begin
            state_nxt_s = DIV_IDLE;
          end else begin
            state_nxt_s = DIV_DONE;
          end
        end
        default:  state_nxt_s = DIV_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= DIV_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Operand capture, iteration datapath and registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r       <= CNT_ZERO;
      rem_r       <= ZERO_R;
      quot_r      <= ZERO_W;
      div_mag_r   <= ZERO_W;
      dividend_r  <= ZERO_W;
      neg_q_r     <= 1'b0;
      neg_r_r     <= 1'b0;
      dbz_r       <= 1'b0;
      tag_r       <= ZERO_T;
      out_valid_r <= 1'b0;
      out_quot_r  <= ZERO_W;
      out_rem_r   <= ZERO_W;
      out_tag_r   <= ZERO_T;
      out_dbz_r   <= 1'b0;
    end else if (flush) begin
      cnt_r       <= CNT_ZERO;
      out_valid_r <= 1'b0;
    end else if (accept_s) begin
      cnt_r       <= CNT_ZERO;
      rem_r       <= ZERO_R;
      quot_r      <= dividend_mag_s;
      div_mag_r   <= divisor_mag_s;
      dividend_r  <= in_dividend;
      neg_q_r     <= in_signed & (in_dividend[WIDTH-1] ^ in_divisor[WIDTH-1]);
      neg_r_r     <= in_signed & in_dividend[WIDTH-1];
      dbz_r       <= (in_divisor == ZERO_W);
      tag_r       <= in_tag;
      out_valid_r <= 1'b0;
    end else if (state_r == DIV_BUSY) begin
      rem_r  <= step_rem_s;
      quot_r <= {quot_r[WIDTH-2:0], step_qbit_s};
      if (last_iter_s) begin
        cnt_r       <= CNT_ZERO;
        out_valid_r <= 1'b1;
        out_quot_r  <= quot_res_s;
        out_rem_r   <= rem_res_s;
        out_tag_r   <= tag_r;
        out_dbz_r   <= dbz_r;
      end else begin
        cnt_r <= cnt_r + CNT_ONE;
      end
    end else if ((state_r == DIV_DONE) && out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

endmodule

// File: doc/iter_divider.md
Name: iter_divider

Overview:
- Parametrised multi-cycle integer divider for the EX stage. It replaces the vendor divider IP pair with one unit that handles signed and unsigned operands and produces quotient and remainder together.
- Uses a radix-2 restoring algorithm: one quotient bit per cycle, fixed latency.
- Valid/ready handshakes on both input and output, a tag carried through with the operation, and a pipeline flush.
- Sits beside the ALU in EX. EX holds its readygo low until out_valid.

Parameters:
- WIDTH, 32, operand/result width in bits; must be ≥ 2.
- TAG_W, 5, width of the opaque tag carried from input to output (e.g. rf_waddr).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  synchronous cancel of any operation in flight.
- in_valid  in  1  operation offered.
- in_ready  out  1  unit can accept an operation this cycle.
- in_signed  in  1  1 = two's-complement operands, 0 = unsigned.
- in_dividend  in  WIDTH  dividend.
- in_divisor  in  WIDTH  divisor.
- in_tag  in  TAG_W  tag returned with the result.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- out_quot  out  WIDTH  quotient.
- out_rem  out  WIDTH  remainder.
- out_tag  out  TAG_W  tag of the completed operation.
- out_dbz  out  1  divisor was zero.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset: state IDLE; out_valid, out_dbz, out_quot, out_rem, out_tag all 0; iteration counter 0.
- States:
  - IDLE: waiting for an operation.
  - BUSY: WIDTH iterations in progress.
  - DONE: result held.
- in_ready = (state==IDLE) | (state==DONE & out_ready). It is combinational from state and out_ready only.
- Accept: in_valid & in_ready & ~flush at an edge. On that edge:
  - Latch |dividend| and |divisor|. Magnitudes are taken only when in_signed; otherwise operands are used raw.
  - Latch sign flags, tag, and dbz = (divisor==0).
  - Clear the partial remainder (WIDTH+1 bits) and the counter. Go to BUSY.
- BUSY, each edge: shift the remainder/quotient pair left by 1. Subtract the divisor magnitude. If the result is non-negative, keep it and set the quotient LSB to 1; else restore.
  - Counter increments.
  - At the edge where the counter reaches WIDTH-1, go to DONE and register the sign-corrected outputs.
- Latency: acceptance at edge k gives out_valid = 1 first in the cycle after edge k+WIDTH. Latency is fixed, including divide-by-zero.
- Sign rules (in_signed = 1):
  - Quotient is negated iff the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Magnitude arithmetic is unsigned WIDTH bits; |MIN| = 2^(WIDTH-1) is representable unsigned.
- MIN / -1 (signed): quotient = MIN, remainder = 0. This falls out of the arithmetic and needs no special case.
- Divide by zero, either mode: out_quot = all ones, out_rem = original dividend, out_dbz = 1.
- DONE:
  - out_valid = 1.
  - out_quot, out_rem, out_tag and out_dbz are held stable until out_valid & out_ready.
  - On out_ready with no new accept, go to IDLE and drop out_valid the next cycle.
  - On out_ready with a simultaneous accept, go directly to BUSY (back-to-back, no idle bubble).
- flush (priority below rst, above everything else):
  - Next state IDLE, out_valid 0, operation discarded.
  - An in_valid in the same cycle as flush is not accepted, even though in_ready may read 1.
  - A result in DONE is dropped even if out_ready = 1.
- Operand inputs are only sampled on the accept edge. Changes at any other time have no effect.
- out_* data while out_valid = 0: hold last values. There is no requirement on content.

Decomposition:
- Shared package (divider_pkg): state encoding constants DIV_IDLE, DIV_BUSY, DIV_DONE; the divide-by-zero quotient constant; the counter width function clog2(WIDTH).
- One sub-module, div_restore_step: combinational single iteration. Inputs: partial remainder, next dividend bit, divisor magnitude. Outputs: new remainder and quotient bit.

Test Plan:
- Unsigned 100 / 7, in_signed = 0, accepted at edge k → out_valid first after edge k+32, quot 14, rem 2, dbz 0, tag echoed.
- Signed -7 / 2 → quot 0xFFFFFFFD, rem 0xFFFFFFFF. Signed 7 / -2 → quot 0xFFFFFFFD, rem 1.
- Signed 0x80000000 / 0xFFFFFFFF → quot 0x80000000, rem 0. Unsigned 0x80000000 / 0xFFFFFFFF → quot 0, rem 0x80000000.
- Divide by zero, 5 / 0, both modes → quot 0xFFFFFFFF, rem 5, dbz 1, same 32-cycle latency.
- Backpressure: hold out_ready = 0 for 10 cycles in DONE → outputs stable and in_ready = 0. Then assert out_ready with a new in_valid the same cycle → new op accepted, next result 32 cycles later.
- Flush 10 cycles into BUSY → out_valid never rises and in_ready = 1 the next cycle. Flush with in_valid in IDLE → op not accepted. rst mid-BUSY → all outputs 0 next cycle.
